// File: rtl/data_mem_access_pkg.sv
// Shared encodings for the data-memory access path: load types, store
// byte-enable patterns, and the alignment rule applied at request time.
package data_mem_access_pkg;

  localparam logic [2:0] LT_NOREGWRITE = 3'd0;
  localparam logic [2:0] LT_LB         = 3'd1;
  localparam logic [2:0] LT_LH         = 3'd2;
  localparam logic [2:0] LT_LW         = 3'd3;
  localparam logic [2:0] LT_LBU        = 3'd4;
  localparam logic [2:0] LT_LHU        = 3'd5;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_SB   = 4'b0001;
  localparam logic [3:0] BE_SH   = 4'b0011;
  localparam logic [3:0] BE_SW   = 4'b1111;

  // Stores win over the load type when any byte enable is set.
  function automatic logic is_misaligned(input logic [3:0] be,
                                         input logic [2:0] lt,
                                         input logic [1:0] lo);
    logic mis;
    if (be != BE_NONE)
      mis = ((be == BE_SH) && lo[0]) || ((be == BE_SW) && (lo != 2'b00));
    else
      mis = (((lt == LT_LH) || (lt == LT_LHU)) && lo[0]) ||
            ((lt == LT_LW) && (lo != 2'b00));
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_access_store_align.sv
// Combinational store lane alignment: shifts byte enables and right-aligned
// store data into the byte lanes selected by the low address bits.
module store_align (
  input  logic [3:0]  be_in,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_in,
  output logic [3:0]  be_out,
  output logic [31:0] wdata_out
);

  // Lane shift by addr[1:0] bytes; bits shifted past the word are dropped.
  always_comb begin
    be_out    = be_in << addr_lo;
    wdata_out = wdata_in << {addr_lo, 3'b000};
  end

endmodule

// File: rtl/data_mem_access.sv
// MEM-stage data memory access controller. Accepts one load/store, issues a
// single word-aligned memory request held until acknowledge, and presents the
// raw read word to the downstream extend stage for one cycle.
// Optional: MISALIGN_TRAP_EN makes misaligned accesses skip the memory and
// pulse misalign_err instead.
module data_mem_access #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [3:0]        req_mem_write,
  input  logic [2:0]        req_load_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              mem_req,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic [1:0]        rd_addr_lo,
  output logic [2:0]        rd_load_type,
  output logic              misalign_err
);

  import data_mem_access_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        lt_q, lt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic [1:0]        rd_addr_lo_q, rd_addr_lo_d;
  logic [2:0]        rd_load_type_q, rd_load_type_d;
`ifdef MISALIGN_TRAP_EN
  logic              mis_q, mis_d;
`endif

  logic [3:0]  be_shift;
  logic [31:0] wdata_shift;

  store_align u_store_align (
    .be_in     (be_q),
    .addr_lo   (addr_q[1:0]),
    .wdata_in  (wdata_q),
    .be_out    (be_shift),
    .wdata_out (wdata_shift)
  );

  // Next-state and output decode for the IDLE/BUSY/DONE access sequence.
  always_comb begin
    state_d        = state_q;
    be_d           = be_q;
    lt_d           = lt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_data_d      = rd_data_q;
    rd_addr_lo_d   = rd_addr_lo_q;
    rd_load_type_d = rd_load_type_q;
`ifdef MISALIGN_TRAP_EN
    mis_d          = mis_q;
`endif
    stall          = 1'b0;
    mem_req        = 1'b0;
    mem_we         = '0;
    mem_addr       = {addr_q[ADDR_W-1:2], 2'b00};
    mem_wdata      = wdata_shift;
    rd_valid       = 1'b0;
    misalign_err   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          stall   = 1'b1;
          be_d    = req_mem_write;
          lt_d    = req_load_type;
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef MISALIGN_TRAP_EN
          mis_d   = is_misaligned(req_mem_write, req_load_type, req_addr[1:0]);
          state_d = mis_d ? S_DONE : S_BUSY;
`else
          state_d = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        mem_we  = (be_q != BE_NONE) ? be_shift : '0;
        if (mem_ack) begin
          state_d = S_DONE;
          // Result registers change only when a load completes, so they hold
          // across stores and new captures.
          if (be_q == BE_NONE) begin
            rd_data_d      = mem_rdata;
            rd_addr_lo_d   = addr_q[1:0];
            rd_load_type_d = lt_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef MISALIGN_TRAP_EN
        misalign_err = mis_q;
        rd_valid     = (be_q == BE_NONE) && !mis_q;
`else
        rd_valid     = (be_q == BE_NONE);
`endif
      end
      default: state_d = S_IDLE;
    endcase

    rd_data      = rd_data_q;
    rd_addr_lo   = rd_addr_lo_q;
    rd_load_type = rd_load_type_q;
  end

  // State and captured-field registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      be_q           <= '0;
      lt_q           <= LT_NOREGWRITE;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_data_q      <= '0;
      rd_addr_lo_q   <= '0;
      rd_load_type_q <= LT_NOREGWRITE;
`ifdef MISALIGN_TRAP_EN
      mis_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      be_q           <= be_d;
      lt_q           <= lt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_data_q      <= rd_data_d;
      rd_addr_lo_q   <= rd_addr_lo_d;
      rd_load_type_q <= rd_load_type_d;
`ifdef MISALIGN_TRAP_EN
      mis_q          <= mis_d;
`endif
    end
  end

endmodule

// File: tb/tb_data_mem_access.sv
// Self-checking bench for data_mem_access: directed scenarios plus randomized
// loads/stores compared against a transaction-level reference model.
module tb_data_mem_access;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [3:0]  req_mem_write;
  logic [2:0]  req_load_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [1:0]  rd_addr_lo;
  logic [2:0]  rd_load_type;
  logic        misalign_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model of the result registers seen by the extend stage.
  logic [31:0] m_rd_data;
  logic [1:0]  m_rd_lo;
  logic [2:0]  m_rd_lt;

  data_mem_access #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_mem_write (req_mem_write),
    .req_load_type (req_load_type),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .stall         (stall),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_addr_lo    (rd_addr_lo),
    .rd_load_type  (rd_load_type),
    .misalign_err  (misalign_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_misaligned(input logic [3:0] be, input logic [2:0] lt,
                                          input logic [31:0] addr);
    int unsigned lo;
    lo = addr % 4;
    if (be != 4'd0)
      return (be == 4'd3 && (lo % 2) == 1) || (be == 4'd15 && lo != 0);
    return ((lt == 3'd2 || lt == 3'd5) && (lo % 2) == 1) || (lt == 3'd3 && lo != 0);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_rdv"}, rd_valid, 0);
    check({tag, "_mis"}, misalign_err, 0);
    check({tag, "_rdd"}, rd_data, m_rd_data);
    check({tag, "_rdlo"}, rd_addr_lo, m_rd_lo);
    check({tag, "_rdlt"}, rd_load_type, m_rd_lt);
  endtask

  // One complete access: acceptance, BUSY cycles with ack on BUSY cycle dly+1,
  // DONE, then back to IDLE with req_valid dropped.
  task automatic do_access(input string tag, input logic [3:0] be, input logic [2:0] lt,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int unsigned dly, input logic [31:0] rdat);
    bit          is_load, mis, trap;
    int unsigned lo, stall_cnt, exp_stall;
    logic [3:0]  exp_we;
    logic [31:0] exp_wd, exp_addr;
    is_load  = (be == 4'd0);
    mis      = model_misaligned(be, lt, addr);
    trap     = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap     = mis;
`endif
    lo       = addr % 4;
    exp_we   = is_load ? 4'd0 : 4'((int'(be) * (1 << lo)) % 16);
    exp_wd   = 32'((64'(wd) * (64'd1 << (8 * lo))) % 64'h1_0000_0000);
    exp_addr = addr - lo;
    stall_cnt = 0;
    exp_stall = trap ? 1 : dly + 2;

    req_valid = 1'b1; req_mem_write = be; req_load_type = lt;
    req_addr = addr; req_wdata = wd;
    #1;
    check({tag, "_acc_stall"}, stall, 1);
    check({tag, "_acc_req"}, mem_req, 0);
    if (stall === 1'b1) stall_cnt++;
    step();

    if (!trap) begin
      for (int unsigned k = 0; k <= dly; k++) begin
        check({tag, "_busy_req"}, mem_req, 1);
        check({tag, "_busy_we"}, mem_we, exp_we);
        check({tag, "_busy_addr"}, mem_addr, exp_addr);
        if (!is_load) check({tag, "_busy_wdata"}, mem_wdata, exp_wd);
        if (stall === 1'b1) stall_cnt++;
        if (k == dly) begin
          mem_ack = 1'b1; mem_rdata = rdat;
        end
        step();
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
    end

    if (is_load && !trap) begin
      m_rd_data = rdat; m_rd_lo = 2'(lo); m_rd_lt = lt;
    end
    check({tag, "_done_stall"}, stall, 0);
    check({tag, "_done_req"}, mem_req, 0);
    check({tag, "_done_rdv"}, rd_valid, (is_load && !trap) ? 1 : 0);
    check({tag, "_done_mis"}, misalign_err, trap ? 1 : 0);
    check({tag, "_done_rdd"}, rd_data, m_rd_data);
    check({tag, "_done_rdlo"}, rd_addr_lo, m_rd_lo);
    check({tag, "_done_rdlt"}, rd_load_type, m_rd_lt);
    check({tag, "_stall_cycles"}, stall_cnt, exp_stall);
    req_valid = 1'b0;
    step();
    check_idle_outputs({tag, "_after"});
  endtask

  initial begin
    logic [3:0]  be;
    logic [2:0]  lt;
    logic [31:0] a;
    rst = 1'b1; req_valid = 1'b0; req_mem_write = 4'd0; req_load_type = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    m_rd_data = 32'd0; m_rd_lo = 2'd0; m_rd_lt = 3'd0;
    step(); step();
    rst = 1'b0;
    check_idle_outputs("reset");

    // Stray acknowledge while idle has no effect.
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 1'b0;
    check_idle_outputs("stray_ack");
    step();
    check_idle_outputs("stray_ack2");

    do_access("sw_0x100", 4'b1111, 3'd0, 32'h100, 32'hDEADBEEF, 2, 32'h0);
    do_access("sb_0x103", 4'b0001, 3'd0, 32'h103, 32'h000000AB, 0, 32'h0);
    do_access("lh_0x206", 4'b0000, 3'd2, 32'h206, 32'h0, 0, 32'h8001_1234);
    do_access("lw_0x301", 4'b0000, 3'd3, 32'h301, 32'h0, 1, 32'hCAFE_F00D);
    do_access("sh_0x102", 4'b0011, 3'd0, 32'h102, 32'h0000_BEEF, 1, 32'h0);

    // Reset in BUSY abandons the access; a late ack is ignored.
    req_valid = 1'b1; req_mem_write = 4'd0; req_load_type = 3'd3;
    req_addr = 32'h400; req_wdata = 32'd0;
    step();
    check("rstbusy_req", mem_req, 1);
    req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_rd_data = 32'd0; m_rd_lo = 2'd0; m_rd_lt = 3'd0;
    check_idle_outputs("rstbusy_idle");
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    check_idle_outputs("rstbusy_ack");
    step();
    check_idle_outputs("rstbusy_ack2");

    // Randomized loads and stores.
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: be = 4'b0001;
        1: be = 4'b0011;
        2: be = 4'b1111;
        default: be = 4'b0000;
      endcase
      lt = 3'($urandom_range(1, 5));
      a  = $urandom;
      do_access("rand", be, lt, a, $urandom, $urandom_range(0, 3), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_access.md
DATA_MEM_ACCESS -- requirements
Module: data_mem_access

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, byte-address width of req_addr/mem_addr.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  MEM stage holds a memory op (load or store).
REQ-005 SHALL have port: req_mem_write  input  4  unshifted store byte enables (0001 SB, 0011 SH, 1111 SW, 0000 load).
REQ-006 SHALL have port: req_load_type  input  3  load type from shared encoding (NOREGWRITE, LB, LH, LW, LBU, LHU).
REQ-007 SHALL have port: req_addr  input  ADDR_W  byte address.
REQ-008 SHALL have port: req_wdata  input  32  store data, right-aligned.
REQ-009 SHALL have port: stall  output  1  freeze pipeline while access is outstanding.
REQ-010 SHALL have port: mem_req / mem_we / mem_addr / mem_wdata  output  1/4/ADDR_W/32  memory request, shifted byte enables, word-aligned address, lane-aligned data.
REQ-011 SHALL have port: mem_ack / mem_rdata  input  1/32  one-cycle acknowledge, raw read word valid with ack.
REQ-012 SHALL have port: rd_valid / rd_data / rd_addr_lo / rd_load_type  output  1/32/2/3  registered raw word, addr[1:0] and load type for the downstream data-extend stage.
REQ-013 SHALL have port: misalign_err  output  1  one-cycle misaligned-access flag.

Function
REQ-014 SHALL implement FSM IDLE, BUSY, DONE.
REQ-015 IDLE: req_valid=1 SHALL capture all req_* fields into registers, assert stall combinationally in the same cycle, and go to BUSY (or DONE per REQ-021).
REQ-016 BUSY: SHALL drive mem_req=1 with mem_we/mem_addr/mem_wdata from captured fields, all held stable until mem_ack; stall=1.
REQ-017 BUSY with mem_ack=1: SHALL capture mem_rdata (loads only), drop mem_req next cycle, go to DONE; ack in the first BUSY cycle is legal (minimum latency: 2 cycles from acceptance to DONE).
REQ-018 DONE: stall=0, rd_valid=1 for loads only, exactly one cycle; SHALL go to IDLE unconditionally without re-accepting the still-present req_valid.
REQ-019 Store SHALL take priority if req_mem_write!=0; mem_we = req_mem_write << addr[1:0]; mem_wdata = req_wdata << (8*addr[1:0]); mem_addr = {addr[ADDR_W-1:2],2'b00}.
REQ-020 Load SHALL drive mem_we=0; rd_data = captured mem_rdata unmodified; rd_addr_lo = captured addr[1:0]; rd_load_type = captured type.
REQ-021 Misaligned = (SH/LH/LHU and addr[0]=1) or (SW/LW and addr[1:0]!=0).
REQ-022 mem_ack outside BUSY SHALL be ignored.
REQ-023 rd_data/rd_addr_lo/rd_load_type SHALL hold last values outside DONE.

Reset
REQ-024 rst=1 SHALL force state IDLE, next cycle: mem_req=0, mem_we=0, stall=0 (unless REQ-015), rd_valid=0, misalign_err=0, rd_data=0, rd_addr_lo=0, rd_load_type=NOREGWRITE.
REQ-025 rst during BUSY SHALL abandon the access; a later mem_ack SHALL be ignored.

Configuration
REQ-026 Macro MISALIGN_TRAP_EN defined: misaligned access SHALL skip BUSY (no mem_req), go IDLE->DONE, pulse misalign_err=1 in DONE, rd_valid=0.
REQ-027 Macro undefined: misalign_err tied 0; misaligned access SHALL be issued normally with low address bits ignored for mem_addr.

Structure
REQ-028 Load-type encodings and store byte-enable constants SHALL live in shared Parameters.v; FSM state encoding local.
REQ-029 One combinational sub-module store_align (byte-enable and data lane shift) SHALL be used.

Verification
REQ-030 SW addr 0x100, data 0xDEADBEEF, ack after 3 BUSY cycles -> mem_we=1111, mem_addr=0x100, stall high 4 cycles total, no rd_valid.
REQ-031 SB addr 0x103, data 0x000000AB -> mem_we=1000, mem_wdata=0xAB000000, mem_addr=0x100.
REQ-032 LH addr 0x206, ack same cycle with rdata 0x8001_1234 -> DONE next cycle: rd_valid=1, rd_data=0x80011234, rd_addr_lo=10, rd_load_type=LH; no second request while req_valid held.
REQ-033 LW addr 0x301 with MISALIGN_TRAP_EN -> no mem_req, misalign_err=1 one cycle; without macro -> mem_addr=0x300, misalign_err=0.
REQ-034 rst asserted in BUSY, then mem_ack -> IDLE, mem_req=0, rd_valid stays 0.
